// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port among writeback, mult/div and I/O.
// WB has priority, MD/IO alternate round-robin, and starvation forces a one-cycle WB stall.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        io_valid,
  input  logic [4:0]  io_reg,
  input  logic [31:0] io_data,
  output logic        io_ready,
  output logic        stall_wb,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        rr_q, rr_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [3:0]  io_cnt_q, io_cnt_d;
  logic        stall_q, stall_d;
  logic        we_q;
  logic [4:0]  wreg_q;
  logic [31:0] wdata_q;

  logic        wb_gnt, md_gnt, io_gnt, any_gnt;
  logic        md_lim, io_lim;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  assign md_lim = (md_cnt_q == LIMIT);
  assign io_lim = (io_cnt_q == LIMIT);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    wb_gnt = 1'b0;
    md_gnt = 1'b0;
    io_gnt = 1'b0;
    if (ctrl_reset_n) begin
      if (wb_valid && !stall_q) begin
        wb_gnt = 1'b1;
      end else if (md_valid && !io_valid) begin
        md_gnt = 1'b1;
      end else if (io_valid && !md_valid) begin
        io_gnt = 1'b1;
      end else if (md_valid && io_valid) begin
        // A lone starved requester overrides the pointer; a tie falls back to round-robin.
        if (stall_q && (md_lim != io_lim)) begin
          md_gnt = md_lim;
          io_gnt = io_lim;
        end else if (rr_q) begin
          io_gnt = 1'b1;
        end else begin
          md_gnt = 1'b1;
        end
      end
    end
  end

  assign any_gnt = wb_gnt | md_gnt | io_gnt;

  always_comb begin
    sel_reg  = wb_reg;
    sel_data = wb_data;
    if (md_gnt) begin
      sel_reg  = md_reg;
      sel_data = md_data;
    end else if (io_gnt) begin
      sel_reg  = io_reg;
      sel_data = io_data;
    end
  end

  always_comb begin
    md_cnt_d = 4'd0;
    io_cnt_d = 4'd0;
    if (md_valid && !md_gnt) md_cnt_d = (md_cnt_q >= LIMIT) ? LIMIT : md_cnt_q + 4'd1;
    if (io_valid && !io_gnt) io_cnt_d = (io_cnt_q >= LIMIT) ? LIMIT : io_cnt_q + 4'd1;
    stall_d = (md_cnt_d == LIMIT) || (io_cnt_d == LIMIT);
    rr_d    = md_gnt ? 1'b1 : (io_gnt ? 1'b0 : rr_q);
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      rr_q     <= 1'b0;
      md_cnt_q <= 4'd0;
      io_cnt_q <= 4'd0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      rr_q     <= rr_d;
      md_cnt_q <= md_cnt_d;
      io_cnt_q <= io_cnt_d;
      stall_q  <= stall_d;
      // r0 is hardwired zero: the grant is consumed but the write is suppressed.
      we_q     <= any_gnt && (sel_reg != 5'd0);
      if (any_gnt) begin
        wreg_q  <= sel_reg;
        wdata_q <= sel_data;
      end
    end
  end

  assign md_ready         = md_gnt;
  assign io_ready         = io_gnt;
  assign stall_wb         = stall_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a stimulus process predicts grants from the
// arbitration rules and queues expected write-port values; a monitor checks them a cycle later.
module tb_regfile_write_arbiter;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
  } req_t;

  typedef struct {
    int          at;
    bit          we;
    logic [4:0]  rg;
    logic [31:0] dat;
    bit          chk;
  } exp_t;

  typedef enum {G_NONE, G_WB, G_MD, G_IO} gnt_e;

  logic        clock;
  logic        ctrl_reset_n;
  req_t        wb_r, md_r, io_r;
  logic        md_ready, io_ready, stall_wb;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .wb_valid         (wb_r.v),
    .wb_reg           (wb_r.r),
    .wb_data          (wb_r.d),
    .md_valid         (md_r.v),
    .md_reg           (md_r.r),
    .md_data          (md_r.d),
    .md_ready         (md_ready),
    .io_valid         (io_r.v),
    .io_reg           (io_r.r),
    .io_data          (io_r.d),
    .io_ready         (io_ready),
    .stall_wb         (stall_wb),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t        sbq[$];
  logic [31:0] rf [32];

  // Reference state: waiting ages, preference and the last value actually written.
  int          m_md_wait, m_io_wait;
  bit          m_io_pref, m_stall, m_init, m_known;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t mk(input bit v, input logic [4:0] r, input logic [31:0] d);
    req_t q;
    q.v = v;
    q.r = r;
    q.d = d;
    return q;
  endfunction

  function automatic int age(input bit v, input bit won, input int w);
    if (!v || won) return 0;
    return (w + 1 > LIMIT) ? LIMIT : w + 1;
  endfunction

  task automatic step(input bit rst_n, input req_t wb, input req_t md, input req_t io,
                      output gnt_e w);
    exp_t e;
    req_t win;
    @(posedge clock);
    #1;
    cyc++;
    ctrl_reset_n = rst_n;
    wb_r = wb;
    md_r = md;
    io_r = io;
    #1;
    w = G_NONE;
    if (m_init) check("stall_wb", stall_wb, 32'(m_stall));
    if (!rst_n) begin
      check("md_ready_in_reset", md_ready, 32'd0);
      check("io_ready_in_reset", io_ready, 32'd0);
      m_md_wait = 0;
      m_io_wait = 0;
      m_io_pref = 0;
      m_stall   = 0;
      m_init    = 1;
      m_reg     = '0;
      m_data    = '0;
      m_known   = 1;
      e = '{cyc + 1, 1'b0, 5'd0, 32'd0, 1'b1};
      sbq.push_back(e);
      return;
    end
    if (wb.v && !m_stall) w = G_WB;
    else if (md.v && !io.v) w = G_MD;
    else if (io.v && !md.v) w = G_IO;
    else if (md.v && io.v) begin
      if (m_stall && ((m_md_wait == LIMIT) != (m_io_wait == LIMIT)))
        w = (m_md_wait == LIMIT) ? G_MD : G_IO;
      else
        w = m_io_pref ? G_IO : G_MD;
    end
    check("md_ready", md_ready, 32'(w == G_MD));
    check("io_ready", io_ready, 32'(w == G_IO));
    m_md_wait = age(md.v, w == G_MD, m_md_wait);
    m_io_wait = age(io.v, w == G_IO, m_io_wait);
    m_stall   = (m_md_wait == LIMIT) || (m_io_wait == LIMIT);
    if (w == G_MD) m_io_pref = 1;
    if (w == G_IO) m_io_pref = 0;
    if (w == G_NONE) begin
      e = '{cyc + 1, 1'b0, m_reg, m_data, m_known};
    end else begin
      win = (w == G_WB) ? wb : (w == G_MD) ? md : io;
      e = '{cyc + 1, win.r != 5'd0, win.r, win.d, win.r != 5'd0};
      m_reg   = win.r;
      m_data  = win.d;
      m_known = (win.r != 5'd0);
    end
    sbq.push_back(e);
  endtask

  task automatic do_reset(input int n);
    gnt_e w;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, w);
  endtask

  // Monitor: compares the write port against the expectation queued for this cycle.
  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0 && sbq[0].at == cyc) begin
        e = sbq.pop_front();
        check("writeEnable", ctrl_writeEnable, 32'(e.we));
        if (e.chk) begin
          check("writeReg", ctrl_writeReg, 32'(e.rg));
          check("writeData", data_writeReg, e.dat);
        end
      end
      if (ctrl_writeEnable === 1'b1) rf[ctrl_writeReg] = data_writeReg;
    end
  end

  initial begin
    req_t wb, md, io;
    gnt_e w;
    ctrl_reset_n = 1'b0;
    wb_r = '0;
    md_r = '0;
    io_r = '0;
    m_init = 0;

    // WB only
    do_reset(2);
    step(1'b1, mk(1, 5'd5, 32'hDEADBEEF), '0, '0, w);
    step(1'b1, '0, '0, '0, w);

    // MD/IO alternation with WB idle, starting from MD
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b1, '0, mk(1, 5'd3, 32'h11), mk(1, 5'd29, 32'h22), w);
    step(1'b1, '0, '0, '0, w);

    // Single starvation under continuous WB traffic
    do_reset(1);
    md = mk(1, 5'd7, 32'hA5A5A5A5);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mk(1, 5'd9, 32'h1000 + i), md, '0, w);
      if (w == G_MD) md = '0;
    end

    // Double starvation: MD then IO served during two stall cycles
    do_reset(1);
    for (int i = 0; i < 10; i++)
      step(1'b1, mk(1, 5'd10, 32'h2000 + i), mk(1, 5'd11, 32'h3000 + i),
           mk(1, 5'd12, 32'h4000 + i), w);

    // r0 write from IO is accepted but suppressed
    do_reset(1);
    step(1'b1, '0, '0, mk(1, 5'd0, 32'hFFFFFFFF), w);
    step(1'b1, '0, '0, '0, w);

    // Reset while MD has waited three cycles; its age restarts afterwards
    do_reset(1);
    md = mk(1, 5'd14, 32'hCAFE0001);
    for (int i = 0; i < 3; i++) step(1'b1, mk(1, 5'd15, 32'h50 + i), md, '0, w);
    step(1'b0, mk(1, 5'd15, 32'h60), md, '0, w);
    for (int i = 0; i < 7 && md.v; i++) begin
      step(1'b1, mk(1, 5'd15, 32'h70 + i), md, '0, w);
      if (w == G_MD) md = '0;
    end

    // Randomized traffic with held requests and occasional reset
    wb = '0;
    md = '0;
    io = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(m_stall && wb.v)) wb = mk($urandom_range(3) != 0, 5'($urandom), $urandom);
      if (!md.v) md = mk($urandom_range(1) == 1, 5'($urandom), $urandom);
      if (!io.v) io = mk($urandom_range(1) == 1, 5'($urandom), $urandom);
      step($urandom_range(63) != 0, wb, md, io, w);
      if (w == G_MD) md = '0;
      if (w == G_IO) io = '0;
    end
    step(1'b1, '0, '0, '0, w);
    step(1'b1, '0, '0, '0, w);

    @(posedge clock);
    #6;
    check("scoreboard_backlog", sbq.size(), 32'd1);
    check("r0_reads_zero", rf[0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among three requesters: pipeline writeback (WB), the multiply/divide unit (MD), and the I/O controller (IO) that deposits peripheral state into the game-mapped registers. WB has priority. MD and IO alternate round-robin in cycles WB leaves free. A per-requester starvation counter forces a one-cycle WB stall when MD or IO waits too long. The block sits between the pipeline/units and the regfile's `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg` inputs.

## Interface
- `STARVE_LIMIT`, 4: consecutive un-granted valid cycles (1..15) after which a WB stall is forced.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `ctrl_reset_n`  in  1  synchronous, active-low reset.
- `wb_valid`, `wb_reg`, `wb_data`  in  1/5/32  writeback request; no ready signal; the pipeline holds the request while `stall_wb`=1.
- `md_valid`, `md_reg`, `md_data`  in  1/5/32  multdiv request; held stable until accepted.
- `md_ready`  out  1  combinational grant to MD this cycle.
- `io_valid`, `io_reg`, `io_data`  in  1/5/32  I/O request; held stable until accepted.
- `io_ready`  out  1  combinational grant to IO this cycle.
- `stall_wb`  out  1  registered; while 1, WB is not granted this cycle.
- `ctrl_writeEnable`  out  1  registered regfile write enable.
- `ctrl_writeReg`  out  5  registered regfile write index.
- `data_writeReg`  out  32  registered regfile write data.

## Operation
**Handshake**
- A request is accepted in any cycle where valid=1 and ready=1 (for WB, where `wb_valid`=1 and `stall_wb`=0).
- At most one request is granted per cycle.

**Grant selection** (evaluated every cycle)
1. If `stall_wb`=0 and `wb_valid`=1, grant WB.
2. Otherwise, if exactly one of MD/IO is valid, grant it.
3. Otherwise, if both are valid:
   - If `stall_wb`=1 and exactly one counter equals `STARVE_LIMIT`, grant that one.
   - Otherwise grant the requester selected by the round-robin pointer `rr`.

**Round-robin pointer**
- `rr`: 0 = MD preferred, 1 = IO preferred.
- On any MD grant, `rr` becomes 1. On any IO grant, `rr` becomes 0.
- `rr` is unchanged in cycles with a WB grant or no grant.

**Starvation counters** (`md_cnt`, `io_cnt`; 4 bits each)
- Valid and not granted: increment, saturating at `STARVE_LIMIT`.
- Granted, or valid=0: clear to 0.
- `stall_wb` next value = (`md_cnt` next == `STARVE_LIMIT`) OR (`io_cnt` next == `STARVE_LIMIT`).

**Write port**
- On a grant, in the next cycle: `ctrl_writeEnable`=1, with `ctrl_writeReg`/`data_writeReg` taken from the winner.
- A granted write to r0 is accepted, but drives `ctrl_writeEnable`=0 (r0 stays zero).
- With no grant: `ctrl_writeEnable`=0, and `ctrl_writeReg`/`data_writeReg` hold their previous values.

**Ordering**
- Writes reach the regfile in grant order. Same-register ordering hazards between units are resolved by the pipeline, not by this block.

**Reset** (`ctrl_reset_n`=0 at an edge)
- `ctrl_writeEnable`=0, `ctrl_writeReg`=0, `data_writeReg`=0, `stall_wb`=0, `rr`=0, `md_cnt`=`io_cnt`=0.
- While `ctrl_reset_n`=0, `md_ready`=`io_ready`=0, so nothing is accepted.
- A request pending when reset asserts is dropped from arbitration state. The requester re-presents it after reset; it is not written.

## Timing
- Request to regfile write: 1 cycle. A request granted in cycle t appears on the write port in cycle t+1, and the regfile captures it at the t+1→t+2 edge.
- `md_ready`/`io_ready` are combinational from valids, `stall_wb` and registered state. There is no combinational path from the ready outputs back to the valid inputs.
- Worst-case wait for MD or IO under continuous WB traffic: `STARVE_LIMIT`+1 cycles. If both MD and IO are starved, the second is served within a further 2 cycles.
- `stall_wb` is high for exactly one cycle per starvation event, plus one more if the other requester is also at limit.
- Back-to-back grants are supported: one write per cycle, with no bubbles.

## Test plan
- **WB only.** After reset, `wb_valid`=1 with reg 5, data 0xDEADBEEF in cycle 0 → cycle 1 has `ctrl_writeEnable`=1, `ctrl_writeReg`=5, `data_writeReg`=0xDEADBEEF; `stall_wb` stays 0.
- **MD/IO alternation.** MD (reg 3, 0x11) and IO (reg 29, 0x22) both valid continuously, WB idle → grants MD, IO, MD, IO…, starting with MD after reset; each write appears 1 cycle after its grant.
- **Starvation.** `wb_valid`=1 every cycle and MD valid from cycle 0, `STARVE_LIMIT`=4 → `md_ready`=0 in cycles 0-3, `stall_wb`=1 in cycle 4 with `md_ready`=1, MD write in cycle 5, `stall_wb`=0 in cycle 5.
- **Double starvation.** WB, MD and IO all valid continuously → `stall_wb`=1 in cycles 4 and 5, granting MD then IO (`rr`=0 after reset).
- **r0 write.** IO write to reg 0, data 0xFFFFFFFF → `io_ready`=1, next cycle `ctrl_writeEnable`=0, and a subsequent read of r0 returns 0.
- **Reset mid-operation.** Assert `ctrl_reset_n`=0 while MD is pending with `md_cnt`=3 → next cycle all outputs are 0 and `md_ready`=0 during reset; after release with MD still valid, MD is granted on the first free cycle, with `md_cnt` restarting from 0.
